// File: rtl/genie_split.sv
// Packet demultiplexer: steers whole valid/ready/eop packets to one of NO outputs
// through a main+skid register slice so every output and o_ready is registered.
module genie_split #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [((WIDTH > 0) ? WIDTH : 1)-1:0]                   i_data,
  input  logic                                                   i_valid,
  output logic                                                   o_ready,
  input  logic                                                   i_eop,
  input  logic [((NO > 1) ? $clog2(NO) : 1)-1:0]                 i_dest,
  output logic [NO-1:0][((WIDTH > 0) ? WIDTH : 1)-1:0]           o_data,
  output logic [NO-1:0]                                          o_valid,
  input  logic [NO-1:0]                                          i_ready,
  output logic [NO-1:0]                                          o_eop,
  output logic                                                   o_drop
);

  localparam int NOBITS = (NO > 1) ? $clog2(NO) : 1;
  localparam int DW     = (WIDTH > 0) ? WIDTH : 1;

  typedef enum logic {S_SOP, S_BODY} state_e;

  typedef struct packed {
    logic [DW-1:0]     data;
    logic              eop;
    logic [NOBITS-1:0] dest;
    logic              valid;
  } beat_t;

  state_e            state_q, state_d;
  logic [NOBITS-1:0] cur_dest_q, cur_dest_d;
  logic              cur_drop_q, cur_drop_d;
  beat_t             m_q, m_d, s_q, s_d, in_beat;
  logic              ready_q, ready_d;
  logic              drop_q, drop_d;

  logic              in_xfer, m_consumed, eff_drop, write_beat;
  logic [NOBITS-1:0] eff_dest;

  assign in_xfer  = i_valid && ready_q;
  assign eff_dest = (state_q == S_SOP) ? i_dest : cur_dest_q;
  assign eff_drop = (state_q == S_SOP) ? (int'(i_dest) >= NO) : cur_drop_q;
  assign write_beat = in_xfer && !eff_drop;

  assign in_beat = '{data: i_data, eop: i_eop, dest: eff_dest, valid: 1'b1};

  always_comb begin
    o_valid = '0;
    o_eop   = '0;
    o_data  = '0;
    for (int k = 0; k < NO; k++) begin
      o_valid[k] = m_q.valid && (int'(m_q.dest) == k);
      o_eop[k]   = m_q.eop && o_valid[k];
      o_data[k]  = (WIDTH > 0) ? m_q.data : '0;
    end
  end

  assign m_consumed = |(o_valid & i_ready);
  assign o_ready    = ready_q;
  assign o_drop     = drop_q;

  // NOTE: every next-state variable gets a default at the top of the block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    cur_drop_d = cur_drop_q;
    m_d        = m_q;
    s_d        = s_q;

    if (in_xfer) begin
      if (state_q == S_SOP) begin
        cur_dest_d = i_dest;
        cur_drop_d = (int'(i_dest) >= NO);
        state_d    = i_eop ? S_SOP : S_BODY;
      end else if (i_eop) begin
        state_d = S_SOP;
      end
    end

    // Skid full means o_ready was low, so no input beat competes this cycle.
    if (s_q.valid) begin
      if (m_consumed) begin
        m_d       = s_q;
        s_d.valid = 1'b0;
      end
    end else if (m_consumed || !m_q.valid) begin
      if (write_beat) m_d = in_beat;
      else            m_d.valid = 1'b0;
    end else if (write_beat) begin
      s_d = in_beat;
    end

    ready_d = !s_d.valid;
    drop_d  = in_xfer && (state_q == S_SOP) && eff_drop;
  end

  // NOTE: only control bits are reset; payload fields are qualified by their
  // valid bits, so clearing them would add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_SOP;
      m_q.valid  <= 1'b0;
      s_q.valid  <= 1'b0;
      ready_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      cur_drop_q <= cur_drop_d;
      m_q        <= m_d;
      s_q        <= s_d;
      ready_q    <= ready_d;
      drop_q     <= drop_d;
    end
  end

endmodule
